id_ex_alu_ctrl: RTL and testbench

Decode-side producer of the 4-bit ALU `Ctrl` code consumed by the bit-slice ALU, fused with the ID/EX pipeline register. Each cycle it decodes one MIPS instruction word into `Ctrl`, immediate and control bits, and registers them for the EX stage. It owns the ID/EX valid/ready handshake, pipeline flush and load-use bubble insertion.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/alu_decode.sv | 114 +++++++++++
 rtl/id_ex_alu_ctrl.sv | 109 ++++++++++
 tb/tb_id_ex_alu_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, functs, ALU Ctrl codes.
// Imported by the decoder and the ID/EX register.
package mips_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [3:0] CTRL_AND  = 4'd0;
    localparam logic [3:0] CTRL_OR   = 4'd1;
    localparam logic [3:0] CTRL_ADD  = 4'd2;
    localparam logic [3:0] CTRL_XOR  = 4'd3;
    localparam logic [3:0] CTRL_SUB  = 4'd10;
    localparam logic [3:0] CTRL_SLT  = 4'd11;
    localparam logic [3:0] CTRL_SLTU = 4'd12;

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decoder: instruction word to ALU Ctrl,
// immediate, destination and control bits.
module alu_decode
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [3:0]      alu_ctrl,
    output logic            alu_src_imm,
    output logic [XLEN-1:0] imm,
    output reg_t            dest,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            branch_ne,
    output logic            uses_rt,
    output logic            illegal
);

    logic [5:0]      opcode;
    logic [5:0]      funct;
    reg_t            rt;
    reg_t            rd;
    logic [XLEN-1:0] sext;
    logic [XLEN-1:0] zext;
    logic            wr;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign sext   = {{(XLEN-16){instr[15]}}, instr[15:0]};
    assign zext   = {{(XLEN-16){1'b0}}, instr[15:0]};

    always_comb begin
        alu_ctrl    = CTRL_ADD;
        alu_src_imm = 1'b0;
        imm         = '0;
        dest        = '0;
        wr          = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        branch      = 1'b0;
        branch_ne   = 1'b0;
        uses_rt     = 1'b0;
        illegal     = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                dest    = rd;
                wr      = 1'b1;
                uses_rt = 1'b1;
                unique case (funct)
                    FN_ADD, FN_ADDU: alu_ctrl = CTRL_ADD;
                    FN_SUB, FN_SUBU: alu_ctrl = CTRL_SUB;
                    FN_AND:          alu_ctrl = CTRL_AND;
                    FN_OR:           alu_ctrl = CTRL_OR;
                    FN_XOR:          alu_ctrl = CTRL_XOR;
                    FN_SLT:          alu_ctrl = CTRL_SLT;
                    FN_SLTU:         alu_ctrl = CTRL_SLTU;
                    default: begin
                        illegal = 1'b1;
                        dest    = '0;
                        wr      = 1'b0;
                        uses_rt = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
                alu_src_imm = 1'b1;
                imm         = sext;
                dest        = rt;
                wr          = 1'b1;
                mem_read    = (opcode == OP_LW);
                if (opcode == OP_SLTI)
                    alu_ctrl = CTRL_SLT;
                else if (opcode == OP_SLTIU)
                    alu_ctrl = CTRL_SLTU;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                alu_src_imm = 1'b1;
                imm         = zext;
                dest        = rt;
                wr          = 1'b1;
                if (opcode == OP_ANDI)
                    alu_ctrl = CTRL_AND;
                else if (opcode == OP_ORI)
                    alu_ctrl = CTRL_OR;
                else
                    alu_ctrl = CTRL_XOR;
            end
            OP_SW: begin
                alu_src_imm = 1'b1;
                imm         = sext;
                dest        = rt;
                mem_write   = 1'b1;
                uses_rt     = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                alu_ctrl  = CTRL_SUB;
                imm       = sext;
                dest      = rt;
                branch    = 1'b1;
                branch_ne = (opcode == OP_BNE);
                uses_rt   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // $0 is hardwired, so a write to it is dropped here
        reg_write = wr & (dest != '0);
    end

endmodule

// File: rtl/id_ex_alu_ctrl.sv
// ID/EX pipeline register fused with the ALU Ctrl decoder;
// owns the valid/ready handshake, flush and load-use bubble.
module id_ex_alu_ctrl
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    output logic            id_ready,
    input  logic            ex_ready,
    input  logic            flush,
    output logic            ex_valid,
    output logic [3:0]      ex_alu_ctrl,
    output logic            ex_alu_src_imm,
    output logic [XLEN-1:0] ex_imm,
    output reg_t            ex_rs,
    output reg_t            ex_rt,
    output reg_t            ex_dest,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_branch_ne,
    output logic            ex_illegal
);

    logic [3:0]      d_alu_ctrl;
    logic            d_alu_src_imm;
    logic [XLEN-1:0] d_imm;
    reg_t            d_dest;
    logic            d_reg_write;
    logic            d_mem_read;
    logic            d_mem_write;
    logic            d_branch;
    logic            d_branch_ne;
    logic            d_uses_rt;
    logic            d_illegal;
    reg_t            id_rs;
    reg_t            id_rt;
    logic            hazard;

    assign id_rs = id_instr[25:21];
    assign id_rt = id_instr[20:16];

    alu_decode #(
        .XLEN(XLEN)
    ) u_dec (
        .instr      (id_instr),
        .alu_ctrl   (d_alu_ctrl),
        .alu_src_imm(d_alu_src_imm),
        .imm        (d_imm),
        .dest       (d_dest),
        .reg_write  (d_reg_write),
        .mem_read   (d_mem_read),
        .mem_write  (d_mem_write),
        .branch     (d_branch),
        .branch_ne  (d_branch_ne),
        .uses_rt    (d_uses_rt),
        .illegal    (d_illegal)
    );

    // Load result is not forwardable until after MEM: stall one cycle
    assign hazard = ex_valid & ex_mem_read & (ex_dest != '0) & id_valid
                  & ((ex_dest == id_rs) | (d_uses_rt & (ex_dest == id_rt)));

    assign id_ready = flush | (ex_ready & ~hazard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_alu_ctrl    <= CTRL_AND;
            ex_alu_src_imm <= 1'b0;
            ex_imm         <= '0;
            ex_rs          <= '0;
            ex_rt          <= '0;
            ex_dest        <= '0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_branch      <= 1'b0;
            ex_branch_ne   <= 1'b0;
            ex_illegal     <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (ex_ready) begin
            if (hazard) begin
                ex_valid <= 1'b0;
            end else begin
                ex_valid       <= id_valid;
                ex_alu_ctrl    <= d_alu_ctrl;
                ex_alu_src_imm <= d_alu_src_imm;
                ex_imm         <= d_imm;
                ex_rs          <= id_rs;
                ex_rt          <= id_rt;
                ex_dest        <= d_dest;
                ex_reg_write   <= d_reg_write;
                ex_mem_read    <= d_mem_read;
                ex_mem_write   <= d_mem_write;
                ex_branch      <= d_branch;
                ex_branch_ne   <= d_branch_ne;
                ex_illegal     <= d_illegal;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Bench for id_ex_alu_ctrl: directed steps then random traffic
// checked against a per-instruction reference model.
module tb_id_ex_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        id_ready;
    logic        ex_ready;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_alu_ctrl;
    logic        ex_alu_src_imm;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_branch_ne;
    logic        ex_illegal;

    always #5 clk = ~clk;

    id_ex_alu_ctrl #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_ready      (id_ready),
        .ex_ready      (ex_ready),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_alu_ctrl   (ex_alu_ctrl),
        .ex_alu_src_imm(ex_alu_src_imm),
        .ex_imm        (ex_imm),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_dest       (ex_dest),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_branch     (ex_branch),
        .ex_branch_ne  (ex_branch_ne),
        .ex_illegal    (ex_illegal)
    );

    typedef struct packed {
        logic        valid;
        logic [3:0]  ctrl;
        logic        src_imm;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        bne;
        logic        ill;
        logic        uses_rt;
    } mrec_t;

    mrec_t m;
    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [31:0] rtype(input logic [5:0] fn,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    // Reference decode written straight from the instruction table
    function automatic mrec_t ref_dec(input logic [31:0] ins);
        mrec_t r;
        logic [5:0] op;
        logic [15:0] i16;
        r = '0;
        op = ins[31:26];
        i16 = ins[15:0];
        r.valid = 1'b1;
        r.rs = ins[25:21];
        r.rt = ins[20:16];
        r.ctrl = 4'd2;
        if (op == 6'h00) begin
            r.dest = ins[15:11];
            r.rw = 1'b1;
            r.uses_rt = 1'b1;
            case (ins[5:0])
                6'h20, 6'h21: r.ctrl = 4'd2;
                6'h22, 6'h23: r.ctrl = 4'd10;
                6'h24: r.ctrl = 4'd0;
                6'h25: r.ctrl = 4'd1;
                6'h26: r.ctrl = 4'd3;
                6'h2A: r.ctrl = 4'd11;
                6'h2B: r.ctrl = 4'd12;
                default: r.ill = 1'b1;
            endcase
        end else begin
            r.dest = ins[20:16];
            r.src_imm = 1'b1;
            r.imm = {{16{i16[15]}}, i16};
            r.rw = 1'b1;
            case (op)
                6'h08, 6'h09: r.ctrl = 4'd2;
                6'h0A: r.ctrl = 4'd11;
                6'h0B: r.ctrl = 4'd12;
                6'h0C: begin r.ctrl = 4'd0; r.imm = {16'h0, i16}; end
                6'h0D: begin r.ctrl = 4'd1; r.imm = {16'h0, i16}; end
                6'h0E: begin r.ctrl = 4'd3; r.imm = {16'h0, i16}; end
                6'h23: r.mr = 1'b1;
                6'h2B: begin r.mw = 1'b1; r.rw = 1'b0; r.uses_rt = 1'b1; end
                6'h04, 6'h05: begin
                    r.ctrl = 4'd10;
                    r.src_imm = 1'b0;
                    r.rw = 1'b0;
                    r.br = 1'b1;
                    r.bne = (op == 6'h05);
                    r.uses_rt = 1'b1;
                end
                default: r.ill = 1'b1;
            endcase
        end
        if (r.ill) begin
            r.ctrl = 4'd2;
            r.rw = 1'b0;
            r.mr = 1'b0;
            r.mw = 1'b0;
            r.br = 1'b0;
            r.bne = 1'b0;
            r.uses_rt = 1'b0;
        end
        if (r.dest == 5'd0)
            r.rw = 1'b0;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
        input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        check("ex_valid", 32'(ex_valid), 32'(m.valid));
        if (m.valid) begin
            check("alu_ctrl", 32'(ex_alu_ctrl), 32'(m.ctrl));
            check("rs", 32'(ex_rs), 32'(m.rs));
            check("rt", 32'(ex_rt), 32'(m.rt));
            check("reg_write", 32'(ex_reg_write), 32'(m.rw));
            check("mem_read", 32'(ex_mem_read), 32'(m.mr));
            check("mem_write", 32'(ex_mem_write), 32'(m.mw));
            check("branch", 32'(ex_branch), 32'(m.br));
            check("branch_ne", 32'(ex_branch_ne), 32'(m.bne));
            check("illegal", 32'(ex_illegal), 32'(m.ill));
            if (!m.ill) begin
                check("src_imm", 32'(ex_alu_src_imm), 32'(m.src_imm));
                check("imm", ex_imm, m.imm);
                check("dest", 32'(ex_dest), 32'(m.dest));
            end
        end
    endtask

    task automatic check_reset();
        check("rst_valid", 32'(ex_valid), 32'd0);
        check("rst_ctrl", 32'(ex_alu_ctrl), 32'd0);
        check("rst_imm", ex_imm, 32'd0);
        check("rst_src_imm", 32'(ex_alu_src_imm), 32'd0);
        check("rst_dest", 32'(ex_dest), 32'd0);
        check("rst_rs_rt", 32'({ex_rs, ex_rt}), 32'd0);
        check("rst_ctl_bits", 32'({ex_reg_write, ex_mem_read, ex_mem_write,
              ex_branch, ex_branch_ne, ex_illegal}), 32'd0);
    endtask

    // Drive one cycle starting just after a rising edge
    task automatic cycle(input logic v, input logic [31:0] ins,
        input logic rdy, input logic fl);
        mrec_t d;
        logic hz;
        id_valid = v;
        id_instr = ins;
        ex_ready = rdy;
        flush = fl;
        d = ref_dec(ins);
        hz = m.valid && m.mr && m.dest != 5'd0 && v &&
             (m.dest == d.rs || (d.uses_rt && m.dest == d.rt));
        #2;
        check("id_ready", 32'(id_ready), 32'(fl | (rdy & ~hz)));
        @(posedge clk);
        #1;
        if (fl) begin
            m.valid = 1'b0;
        end else if (rdy) begin
            if (hz) begin
                m.valid = 1'b0;
            end else begin
                m = d;
                m.valid = v;
            end
        end
        check_regs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        m = '0;
        check_reset();
        @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;
    endtask

    logic [31:0] ins;
    logic [5:0]  ops [16];
    logic [5:0]  fns [10];

    initial begin
        ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                6'h0D, 6'h0E, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A,
                6'h2B, 6'h00};
        id_valid = 1'b0;
        id_instr = '0;
        ex_ready = 1'b1;
        flush = 1'b0;
        m = '0;
        #1;
        do_reset();

        cycle(1'b1, 32'h00221820, 1'b1, 1'b0);
        check("add_valid", 32'(ex_valid), 32'd1);
        check("add_ctrl", 32'(ex_alu_ctrl), 32'd2);
        check("add_dest", 32'(ex_dest), 32'd3);
        check("add_rw", 32'(ex_reg_write), 32'd1);
        check("add_src", 32'(ex_alu_src_imm), 32'd0);

        cycle(1'b1, itype(6'h0C, 5'd5, 5'd4, 16'h8001), 1'b1, 1'b0);
        check("andi_ctrl", 32'(ex_alu_ctrl), 32'd0);
        check("andi_imm", ex_imm, 32'h00008001);
        cycle(1'b1, itype(6'h0A, 5'd5, 5'd4, 16'h8001), 1'b1, 1'b0);
        check("slti_ctrl", 32'(ex_alu_ctrl), 32'd11);
        check("slti_imm", ex_imm, 32'hFFFF8001);

        cycle(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0), 1'b1, 1'b0);
        cycle(1'b1, rtype(6'h22, 5'd2, 5'd4, 5'd3), 1'b1, 1'b0);
        check("lu_bubble", 32'(ex_valid), 32'd0);
        cycle(1'b1, rtype(6'h22, 5'd2, 5'd4, 5'd3), 1'b1, 1'b0);
        check("lu_sub_valid", 32'(ex_valid), 32'd1);
        check("lu_sub_ctrl", 32'(ex_alu_ctrl), 32'd10);

        cycle(1'b1, itype(6'h23, 5'd1, 5'd0, 16'h0), 1'b1, 1'b0);
        cycle(1'b1, rtype(6'h22, 5'd0, 5'd4, 5'd3), 1'b1, 1'b0);
        check("ld0_no_bubble", 32'(ex_valid), 32'd1);

        cycle(1'b1, itype(6'h04, 5'd1, 5'd2, 16'h0010), 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'h00221820, 1'b0, 1'b0);
            check("hold_ctrl", 32'(ex_alu_ctrl), 32'd10);
            check("hold_branch", 32'(ex_branch), 32'd1);
        end
        cycle(1'b1, 32'h00221820, 1'b1, 1'b0);
        check("release_ctrl", 32'(ex_alu_ctrl), 32'd2);

        cycle(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0), 1'b1, 1'b0);
        cycle(1'b1, rtype(6'h22, 5'd2, 5'd4, 5'd3), 1'b0, 1'b1);
        check("flush_valid", 32'(ex_valid), 32'd0);

        cycle(1'b1, itype(6'h3F, 5'd1, 5'd2, 16'h1234), 1'b1, 1'b0);
        check("ill_op", 32'(ex_illegal), 32'd1);
        check("ill_op_wr", 32'({ex_reg_write, ex_mem_write}), 32'd0);
        cycle(1'b1, rtype(6'h00, 5'd1, 5'd2, 5'd3), 1'b1, 1'b0);
        check("ill_fn", 32'(ex_illegal), 32'd1);
        check("ill_fn_wr", 32'({ex_reg_write, ex_mem_write}), 32'd0);

        for (int i = 0; i < 600; i++) begin
            if (i == 300)
                do_reset();
            ins = $urandom();
            ins[31:26] = ops[$urandom_range(0, 15)];
            if (ins[31:26] == 6'h00)
                ins[5:0] = fns[$urandom_range(0, 9)];
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            ins[15:11] = ($urandom_range(0, 3) == 0) ? ins[15:11]
                                                     : 5'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 4) != 0), ins,
                  1'($urandom_range(0, 4) != 0),
                  1'($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
